// File: rtl/pcie_msi_pkg.sv
// Shared types, widths and the vector-folding helper for the MSI request generator.
package pcie_msi_pkg;

    localparam int MSI_NUM_W = 5;
    localparam int MAX_IRQ   = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } msi_state_e;

    // The host may grant fewer vectors than sources; drop the upper index bits.
    function automatic logic [MSI_NUM_W-1:0] fold_vector(input logic [MSI_NUM_W-1:0] idx,
                                                         input logic [2:0] mme);
        logic [2:0]         lim;
        logic [MSI_NUM_W:0] msk;
        lim = (mme > 3'd5) ? 3'd5 : mme;
        msk = (6'd1 << lim) - 6'd1;
        return idx & msk[MSI_NUM_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, with wrap.
module rr_arbiter
    import pcie_msi_pkg::*;
#(
    parameter int NUM_REQ = 8
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [MSI_NUM_W-1:0] last_grant_i,
    output logic [MSI_NUM_W-1:0] grant_idx_o,
    output logic                 grant_valid_o
);

    int unsigned idx;

    always_comb begin
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(last_grant_i) + 32'(off)) % 32'(NUM_REQ);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx[MSI_NUM_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pcie_msi_arbiter.sv
// Latches edge/level interrupt sources as pending and issues them one at a time
// as app_msi_req/app_msi_ack transactions to the PCIe core.
module pcie_msi_arbiter
    import pcie_msi_pkg::*;
#(
    parameter int               NUM_IRQ    = 8,
    parameter logic [NUM_IRQ-1:0] LEVEL_MASK = '0,
    parameter int               HOLDOFF    = 4096,
    parameter logic [2:0]       MSI_TC     = 3'b000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               msi_enable,
    input  logic [2:0]         msi_mme,
    output logic               app_msi_req,
    output logic [4:0]         app_msi_num,
    output logic [2:0]         app_msi_tc,
    output logic               app_int_sts,
    input  logic               app_msi_ack,
    input  logic               app_int_ack,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam int HO_W = $clog2(HOLDOFF);

    logic [NUM_IRQ-1:0]   irq_r_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   serviced_q, serviced_d;
    logic [HO_W-1:0]      ho_cnt_q, ho_cnt_d;
    msi_state_e           state_q;
    logic                 req_q;
    logic [MSI_NUM_W-1:0] num_q;
    logic [MSI_NUM_W-1:0] last_q;

    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   grant_oh;
    logic [NUM_IRQ-1:0]   edge_set, level_set;
    logic [MSI_NUM_W-1:0] grant_idx;
    logic                 grant_valid;
    logic                 grant_fire;
    logic                 ho_strobe;
    logic                 unused_int_ack;

    assign unused_int_ack = app_int_ack;

    assign eligible   = pending_q & ~irq_mask & {NUM_IRQ{msi_enable}};
    assign grant_fire = (state_q == IDLE) && grant_valid;
    assign ho_strobe  = (ho_cnt_q == HO_W'(HOLDOFF - 1));
    assign ho_cnt_d   = ho_strobe ? '0 : ho_cnt_q + 1'b1;

    rr_arbiter #(.NUM_REQ(NUM_IRQ)) u_rr (
        .req_i         (eligible),
        .last_grant_i  (last_q),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // A level source being granted this cycle must not re-pend off its own still-high line.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            grant_oh[i] = grant_fire && (grant_idx == MSI_NUM_W'(i));
        end
        edge_set   = irq & ~irq_r_q & ~LEVEL_MASK;
        level_set  = irq & ~serviced_q & LEVEL_MASK & ~grant_oh;
        pending_d  = (pending_q & ~grant_oh) | edge_set | level_set;
        serviced_d = grant_oh | (serviced_q & irq & ~{NUM_IRQ{ho_strobe}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_r_q    <= '0;
            pending_q  <= '0;
            serviced_q <= '0;
            ho_cnt_q   <= '0;
        end else begin
            irq_r_q    <= irq;
            pending_q  <= pending_d;
            serviced_q <= serviced_d;
            ho_cnt_q   <= ho_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            num_q   <= '0;
            last_q  <= MSI_NUM_W'(NUM_IRQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        req_q   <= 1'b1;
                        num_q   <= fold_vector(grant_idx, msi_mme);
                        last_q  <= grant_idx;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (app_msi_ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign app_msi_req = req_q;
    assign app_msi_num = num_q;
    assign app_msi_tc  = MSI_TC;
    assign app_int_sts = 1'b0;
    assign irq_pending = pending_q;

endmodule
